// File: rtl/ledmatrix_pkg.sv
// Shared definitions for the LED matrix serial link: register addresses,
// receiver state encoding and the code-B segment table.
package ledmatrix_pkg;

    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SHIFT = 2'd1,
        RX_LATCH = 2'd2
    } t_rx_state;

    // Code-B font, segments {a,b,c,d,e,f,g} on bits [6:0].
    function automatic logic [6:0] codeb_segs(input logic [3:0] code);
        logic [6:0] segs;
        case (code)
            4'h0:    segs = 7'h7E;
            4'h1:    segs = 7'h30;
            4'h2:    segs = 7'h6D;
            4'h3:    segs = 7'h79;
            4'h4:    segs = 7'h33;
            4'h5:    segs = 7'h5B;
            4'h6:    segs = 7'h5F;
            4'h7:    segs = 7'h70;
            4'h8:    segs = 7'h7F;
            4'h9:    segs = 7'h7B;
            4'hA:    segs = 7'h01;  // '-'
            4'hB:    segs = 7'h4F;  // 'E'
            4'hC:    segs = 7'h37;  // 'H'
            4'hD:    segs = 7'h0E;  // 'L'
            4'hE:    segs = 7'h67;  // 'P'
            default: segs = 7'h00;  // blank
        endcase
        return segs;
    endfunction

endpackage

// File: rtl/ledmatrix_rx_codeb_decoder.sv
// Code-B digit to seven-segment lookup for one display row.
module codeb_decoder
    import ledmatrix_pkg::*;
(
    input  logic [3:0] in_code,
    output logic [6:0] out_segs
);

    // Pure table lookup; the row register downstream provides the timing.
    always_comb begin
        out_segs = codeb_segs(in_code);
    end

endmodule

// File: rtl/ledmatrix_rx.sv
// Receiving end of the MAX7219-style serial link. Synchronises the pins,
// assembles 16-bit {addr, data} words, updates the display registers and
// renders the registered pixel matrix.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RX_IDLE  | chip select low, waiting for it to rise
// RX_SHIFT | chip select high, shifting one bit per sclk rising edge
// RX_LATCH | chip select just fell; accept the word or flag a short word
module ledmatrix_rx
    import ledmatrix_pkg::*;
#(
    parameter int NUM_SEGS     = 8,
    parameter int LEDS_PER_SEG = 8,
    parameter int WORD_BITS    = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                             in_clk,
    input  logic                             in_rst,
    input  logic                             in_sclk,
    input  logic                             in_mosi,
    input  logic                             in_cs,
    output logic                             out_dout,
    output logic [NUM_SEGS*LEDS_PER_SEG-1:0] out_pixels,
    output logic                             out_shutdown,
    output logic                             out_test,
    output logic [3:0]                       out_intensity,
    output logic [2:0]                       out_scan_limit,
    output logic [7:0]                       out_decode,
    output logic [WORD_BITS-1:0]             out_word,
    output logic                             out_word_valid,
    output logic                             out_err
);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q,   cs_prev_d;

    t_rx_state              state_q, state_d;
    logic [4:0]             bit_ctr_q, bit_ctr_d;
    logic [WORD_BITS-1:0]   shift_q, shift_d;
    logic [WORD_BITS-1:0]   word_q, word_d;
    logic                   word_valid_q, word_valid_d;
    logic                   err_q, err_d;

    logic [LEDS_PER_SEG-1:0] digit_q [NUM_SEGS];
    logic [LEDS_PER_SEG-1:0] digit_d [NUM_SEGS];
    logic [7:0]             decode_q, decode_d;
    logic [3:0]             intensity_q, intensity_d;
    logic [2:0]             scan_limit_q, scan_limit_d;
    logic                   shutdown_q, shutdown_d;
    logic                   test_q, test_d;
    logic [NUM_SEGS*LEDS_PER_SEG-1:0] pixels_q, pixels_d;

    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, cs_rise;
    logic [3:0]             rx_addr;
    logic [7:0]             rx_data;
    logic [6:0]             segs [NUM_SEGS];

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign rx_addr   = shift_q[11:8];
    assign rx_data   = shift_q[7:0];

    genvar g;
    generate
        for (g = 0; g < NUM_SEGS; g++) begin : g_row
            codeb_decoder u_codeb (
                .in_code  (digit_q[g][3:0]),
                .out_segs (segs[g])
            );
        end
    endgenerate

    // Pin synchronisers followed by one stage of edge-detect history.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], in_sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   in_cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], in_mosi};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
    end

    // Receive FSM next state plus register-file writes on an accepted word.
    always_comb begin
        state_d      = state_q;
        bit_ctr_d    = bit_ctr_q;
        shift_d      = shift_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        err_d        = 1'b0;
        digit_d      = digit_q;
        decode_d     = decode_q;
        intensity_d  = intensity_q;
        scan_limit_d = scan_limit_q;
        shutdown_d   = shutdown_q;
        test_d       = test_q;

        case (state_q)
            RX_IDLE: begin
                if (cs_rise) begin
                    state_d   = RX_SHIFT;
                    bit_ctr_d = '0;
                end
            end
            RX_SHIFT: begin
                // A final sclk edge seen together with cs low is still kept.
                if (sclk_rise) begin
                    shift_d = {shift_q[WORD_BITS-2:0], mosi_s};
                    if (bit_ctr_q != 5'd31) begin
                        bit_ctr_d = bit_ctr_q + 5'd1;
                    end
                end
                if (!cs_s) begin
                    state_d = RX_LATCH;
                end
            end
            RX_LATCH: begin
                if (bit_ctr_q >= 5'(WORD_BITS)) begin
                    word_d       = shift_q;
                    word_valid_d = 1'b1;
                    for (int i = 0; i < NUM_SEGS; i++) begin
                        if (rx_addr == 4'(i + 1)) begin
                            digit_d[i] = rx_data;
                        end
                    end
                    case (rx_addr)
                        ADDR_DECODE:    decode_d     = rx_data;
                        ADDR_INTENSITY: intensity_d  = rx_data[3:0];
                        ADDR_SCANLIMIT: scan_limit_d = rx_data[2:0];
                        ADDR_SHUTDOWN:  shutdown_d   = ~rx_data[0];
                        ADDR_TEST:      test_d       = rx_data[0];
                        default:        ;
                    endcase
                end else begin
                    err_d = 1'b1;
                end
                // Back-to-back words: cs already high again restarts the count.
                if (cs_s) begin
                    state_d   = RX_SHIFT;
                    bit_ctr_d = '0;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Pixel rendering: test beats shutdown, rows beyond the scan limit stay dark.
    always_comb begin
        pixels_d = '0;
        for (int i = 0; i < NUM_SEGS; i++) begin
            if (test_q) begin
                pixels_d[i*LEDS_PER_SEG +: LEDS_PER_SEG] = '1;
            end else if (shutdown_q || (i > int'(scan_limit_q))) begin
                pixels_d[i*LEDS_PER_SEG +: LEDS_PER_SEG] = '0;
            end else if (decode_q[i]) begin
                pixels_d[i*LEDS_PER_SEG +: LEDS_PER_SEG] = {digit_q[i][7], segs[i]};
            end else begin
                pixels_d[i*LEDS_PER_SEG +: LEDS_PER_SEG] = digit_q[i];
            end
        end
    end

    // All state registers; reset leaves the display shut down and discards any partial word.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            sclk_sync_q  <= '0;
            cs_sync_q    <= '0;
            mosi_sync_q  <= '0;
            sclk_prev_q  <= 1'b0;
            cs_prev_q    <= 1'b0;
            state_q      <= RX_IDLE;
            bit_ctr_q    <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            err_q        <= 1'b0;
            for (int i = 0; i < NUM_SEGS; i++) begin
                digit_q[i] <= '0;
            end
            decode_q     <= '0;
            intensity_q  <= '0;
            scan_limit_q <= '0;
            shutdown_q   <= 1'b1;
            test_q       <= 1'b0;
            pixels_q     <= '0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            cs_prev_q    <= cs_prev_d;
            state_q      <= state_d;
            bit_ctr_q    <= bit_ctr_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            err_q        <= err_d;
            digit_q      <= digit_d;
            decode_q     <= decode_d;
            intensity_q  <= intensity_d;
            scan_limit_q <= scan_limit_d;
            shutdown_q   <= shutdown_d;
            test_q       <= test_d;
            pixels_q     <= pixels_d;
        end
    end

    assign out_dout       = shift_q[WORD_BITS-1];
    assign out_pixels     = pixels_q;
    assign out_shutdown   = shutdown_q;
    assign out_test       = test_q;
    assign out_intensity  = intensity_q;
    assign out_scan_limit = scan_limit_q;
    assign out_decode     = decode_q;
    assign out_word       = word_q;
    assign out_word_valid = word_valid_q;
    assign out_err        = err_q;

endmodule
